// File: rtl/dma_pcie_cq_cc_responder_if.sv
// CQ/CC AXI-Stream pair between the PCIe core (master) and the BAR responder (slave).
// Signal names follow the PCIe core's cq_*/cc_* stream naming.
interface dma_pcie_cq_cc_responder_if #(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned CQ_USER_WIDTH = 183,
  parameter int unsigned CC_USER_WIDTH = 81
);
  logic [DATA_WIDTH-1:0]    cq_tdata;
  logic [CQ_USER_WIDTH-1:0] cq_tuser;
  logic                     cq_tlast;
  logic [DATA_WIDTH/32-1:0] cq_tkeep;
  logic                     cq_tvalid;
  logic [21:0]              cq_tready;

  logic [DATA_WIDTH-1:0]    cc_tdata;
  logic [CC_USER_WIDTH-1:0] cc_tuser;
  logic                     cc_tlast;
  logic [DATA_WIDTH/32-1:0] cc_tkeep;
  logic                     cc_tvalid;
  logic                     cc_tready;

  modport slave (
    input  cq_tdata, cq_tuser, cq_tlast, cq_tkeep, cq_tvalid, cc_tready,
    output cq_tready, cc_tdata, cc_tuser, cc_tlast, cc_tkeep, cc_tvalid
  );

  modport master (
    output cq_tdata, cq_tuser, cq_tlast, cq_tkeep, cq_tvalid, cc_tready,
    input  cq_tready, cc_tdata, cc_tuser, cc_tlast, cc_tkeep, cc_tvalid
  );
endinterface

// File: rtl/dma_pcie_cq_cc_responder.sv
// Single-BAR completer: MemWr/MemRd of a 32-bit register file over the CQ/CC pair.
// Optional DMA_CQ_CC_RESP_STATS_EN adds saturating read/write/UR counters.
module dma_pcie_cq_cc_responder #(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned CQ_USER_WIDTH = 183,
  parameter int unsigned CC_USER_WIDTH = 81,
  parameter int unsigned NUM_REGS      = 16,
  parameter int unsigned BAR_ID        = 0
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  dma_pcie_cq_cc_responder_if.slave     bus,
  input  logic [15:0]                   completer_id,
  output logic                          reg_wr_pulse,
  output logic [7:0]                    reg_wr_idx
`ifdef DMA_CQ_CC_RESP_STATS_EN
  ,
  output logic [31:0]                   stat_rd_cnt,
  output logic [31:0]                   stat_wr_cnt,
  output logic [31:0]                   stat_ur_cnt
`endif
);
  localparam int unsigned KeepW = DATA_WIDTH / 32;
  localparam int unsigned IdxW  = $clog2(NUM_REGS);
  localparam logic [2:0]  BarId = 3'(BAR_ID);

  typedef enum logic [1:0] {StIdle, StDrain, StCplFmt, StCpl} state_e;

  state_e                 state_q;
  logic [31:0]            regs_q [NUM_REGS];
  logic [21:0]            cq_tready_q;
  logic [DATA_WIDTH-1:0]  cc_tdata_q;
  logic [KeepW-1:0]       cc_tkeep_q;
  logic                   cc_tvalid_q, cc_tlast_q;
  logic [4:0]             addr_q;
  logic [3:0]             be_q;
  logic                   sc_q, drain_q;
  logic [15:0]            req_id_q;
  logic [7:0]             tag_q;
  logic [2:0]             tc_q, attr_q;
  logic [31:0]            rd_data_q;

  logic [127:0]           desc;
  logic [IdxW-1:0]        idx;
  logic [3:0]             first_be;
  logic [31:0]            wr_data;
  logic                   accept, bar_hit, wr_hit, rd_hit;

  assign desc     = bus.cq_tdata[127:0];
  assign idx      = desc[IdxW+1:2];
  assign first_be = bus.cq_tuser[3:0];
  assign wr_data  = bus.cq_tdata[159:128];
  assign accept   = bus.cq_tvalid & cq_tready_q[0];
  assign bar_hit  = (desc[114:112] == BarId);
  assign wr_hit   = accept && (state_q == StIdle) && bar_hit && (desc[78:75] == 4'd1) &&
                    (desc[74:64] == 11'd1);
  assign rd_hit   = accept && (state_q == StIdle) && bar_hit && (desc[78:75] == 4'd0);

  assign bus.cq_tready = cq_tready_q;
  assign bus.cc_tdata  = cc_tdata_q;
  assign bus.cc_tkeep  = cc_tkeep_q;
  assign bus.cc_tvalid = cc_tvalid_q;
  assign bus.cc_tlast  = cc_tlast_q;
  assign bus.cc_tuser  = '0;

  logic unused_in;
  assign unused_in = ^{bus.cq_tdata, bus.cq_tuser, bus.cq_tkeep};

  // First/last enabled byte give lower_addr[1:0] and byte_count; empty BE counts as one byte.
  logic [1:0]   lo2, hi2;
  logic [12:0]  byte_cnt;
  logic [127:0] cpl_desc;
  always_comb begin
    lo2 = 2'd0;
    hi2 = 2'd0;
    for (int i = 3; i >= 0; i--) if (be_q[i]) lo2 = 2'(i);
    for (int i = 0; i < 4; i++) if (be_q[i]) hi2 = 2'(i);
    if (!sc_q)              byte_cnt = 13'd4;
    else if (be_q == 4'd0)  byte_cnt = 13'd1;
    else                    byte_cnt = 13'(hi2) - 13'(lo2) + 13'd1;
    cpl_desc           = '0;
    cpl_desc[6:0]      = {addr_q, lo2};
    cpl_desc[28:16]    = byte_cnt;
    cpl_desc[42:32]    = sc_q ? 11'd1 : 11'd0;
    cpl_desc[45:43]    = sc_q ? 3'b000 : 3'b001;
    cpl_desc[63:48]    = req_id_q;
    cpl_desc[71:64]    = tag_q;
    cpl_desc[87:72]    = completer_id;
    cpl_desc[91:89]    = tc_q;
    cpl_desc[94:92]    = attr_q;
    cpl_desc[127:96]   = sc_q ? rd_data_q : 32'd0;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (first_be[b]) regs_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q      <= StIdle;
      cq_tready_q  <= '1;
      cc_tdata_q   <= '0;
      cc_tkeep_q   <= '0;
      cc_tvalid_q  <= 1'b0;
      cc_tlast_q   <= 1'b0;
      reg_wr_pulse <= 1'b0;
      reg_wr_idx   <= '0;
      addr_q       <= '0;
      be_q         <= '0;
      sc_q         <= 1'b0;
      drain_q      <= 1'b0;
      req_id_q     <= '0;
      tag_q        <= '0;
      tc_q         <= '0;
      attr_q       <= '0;
      rd_data_q    <= '0;
    end else begin
      reg_wr_pulse <= wr_hit;
      if (wr_hit) reg_wr_idx <= 8'(idx);
      unique case (state_q)
        StIdle: begin
          if (rd_hit) begin
            // Capture the register now so later writes cannot change the completion.
            addr_q      <= desc[6:2];
            be_q        <= first_be;
            sc_q        <= (desc[74:64] == 11'd1);
            drain_q     <= !bus.cq_tlast;
            req_id_q    <= desc[95:80];
            tag_q       <= desc[103:96];
            tc_q        <= desc[123:121];
            attr_q      <= desc[126:124];
            rd_data_q   <= regs_q[idx];
            cq_tready_q <= '0;
            state_q     <= StCplFmt;
          end else if (accept && !bus.cq_tlast) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (accept && bus.cq_tlast) state_q <= StIdle;
        end
        StCplFmt: begin
          cc_tdata_q  <= DATA_WIDTH'(cpl_desc);
          cc_tkeep_q  <= sc_q ? KeepW'(4'hF) : KeepW'(4'h7);
          cc_tvalid_q <= 1'b1;
          cc_tlast_q  <= 1'b1;
          state_q     <= StCpl;
        end
        StCpl: begin
          if (bus.cc_tready) begin
            cc_tvalid_q <= 1'b0;
            cc_tlast_q  <= 1'b0;
            cq_tready_q <= '1;
            state_q     <= drain_q ? StDrain : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DMA_CQ_CC_RESP_STATS_EN
  logic cc_done;
  assign cc_done = (state_q == StCpl) && bus.cc_tready;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
      stat_ur_cnt <= '0;
    end else begin
      if (cc_done && sc_q && (stat_rd_cnt != '1))  stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if (cc_done && !sc_q && (stat_ur_cnt != '1)) stat_ur_cnt <= stat_ur_cnt + 32'd1;
      if (wr_hit && (stat_wr_cnt != '1))           stat_wr_cnt <= stat_wr_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dma_pcie_cq_cc_responder.sv
// Directed, table-driven bench for the CQ/CC BAR responder plus multi-cycle corner sequences.
module tb_dma_pcie_cq_cc_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] completer_id = 16'hABCD;
  logic        reg_wr_pulse;
  logic [7:0]  reg_wr_idx;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dma_pcie_cq_cc_responder_if #(.DATA_WIDTH(512), .CQ_USER_WIDTH(183), .CC_USER_WIDTH(81)) bus ();

`ifdef DMA_CQ_CC_RESP_STATS_EN
  logic [31:0] stat_rd_cnt, stat_wr_cnt, stat_ur_cnt;
`endif

  dma_pcie_cq_cc_responder #(
    .DATA_WIDTH(512), .CQ_USER_WIDTH(183), .CC_USER_WIDTH(81), .NUM_REGS(16), .BAR_ID(0)
  ) dut (
    .axi_aclk     (clk),
    .axi_aresetn  (rst_n),
    .bus          (bus),
    .completer_id (completer_id),
    .reg_wr_pulse (reg_wr_pulse),
    .reg_wr_idx   (reg_wr_idx)
`ifdef DMA_CQ_CC_RESP_STATS_EN
    ,
    .stat_rd_cnt  (stat_rd_cnt),
    .stat_wr_cnt  (stat_wr_cnt),
    .stat_ur_cnt  (stat_ur_cnt)
`endif
  );

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [10:0] dw;
    logic [7:0]  tag;
    logic [2:0]  bar;
    logic [2:0]  tc;
    logic [2:0]  attr;
    bit          exp_pulse;
    logic [7:0]  exp_idx;
    bit          exp_cpl;
    logic [2:0]  exp_status;
    logic [12:0] exp_bc;
    logic [6:0]  exp_la;
    logic [10:0] exp_dwc;
    logic [31:0] exp_pl;
    logic [15:0] exp_keep;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] mk_desc(input bit wr, input logic [63:0] addr,
                                           input logic [10:0] dw, input logic [7:0] tag,
                                           input logic [2:0] bar, input logic [2:0] tc,
                                           input logic [2:0] attr);
    logic [127:0] d;
    d          = '0;
    d[63:0]    = addr;
    d[74:64]   = dw;
    d[78:75]   = wr ? 4'd1 : 4'd0;
    d[95:80]   = 16'h1234;
    d[103:96]  = tag;
    d[114:112] = bar;
    d[123:121] = tc;
    d[126:124] = attr;
    return d;
  endfunction

  function automatic logic [127:0] exp_desc(input vec_t v);
    return {v.exp_pl, 1'b0, v.attr, v.tc, 1'b0, 16'hABCD, v.tag, 16'h1234, 2'b00,
            v.exp_status, v.exp_dwc, 3'b000, v.exp_bc, 9'd0, v.exp_la};
  endfunction

  task automatic drive_beat(input logic [127:0] desc, input logic [31:0] dw0,
                            input logic [3:0] be, input logic last);
    bit ok;
    @(negedge clk);
    bus.cq_tdata           = '0;
    bus.cq_tdata[127:0]    = desc;
    bus.cq_tdata[159:128]  = dw0;
    bus.cq_tuser           = '0;
    bus.cq_tuser[3:0]      = be;
    bus.cq_tkeep           = '1;
    bus.cq_tlast           = last;
    bus.cq_tvalid          = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.cq_tready[0]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    bus.cq_tvalid = 1'b0;
    chk("cq_accept", 128'(ok), 128'd1);
  endtask

  task automatic wait_cc(output int lat, output logic [21:0] rdy_first);
    bit ok;
    lat = 0;
    ok = 1'b0;
    rdy_first = '1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) rdy_first = bus.cq_tready;
      if (bus.cc_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("cc_valid_seen", 128'(ok), 128'd1);
  endtask

  task automatic handshake();
    bus.cc_tready = 1'b1;
    @(posedge clk);
    #1;
    bus.cc_tready = 1'b0;
    chk("cc_valid_after_hs", 128'(bus.cc_tvalid), 128'd0);
    chk("cq_ready_after_hs", 128'(bus.cq_tready), 128'h3FFFFF);
  endtask

  task automatic no_cc(input string name);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.cc_tvalid || (bus.cq_tready != 22'h3FFFFF)) bad = 1'b1;
    end
    chk(name, 128'(bad), 128'd0);
  endtask

  task automatic rd_check(input string name, input logic [63:0] addr, input logic [7:0] tag,
                          input logic [31:0] exp_pl);
    int          lat;
    logic [21:0] r0;
    drive_beat(mk_desc(1'b0, addr, 11'd1, tag, 3'd0, 3'd0, 3'd0), 32'd0, 4'hF, 1'b1);
    wait_cc(lat, r0);
    chk({name, "_tag"}, 128'(bus.cc_tdata[71:64]), 128'(tag));
    chk({name, "_status"}, 128'(bus.cc_tdata[45:43]), 128'd0);
    chk({name, "_payload"}, 128'(bus.cc_tdata[127:96]), 128'(exp_pl));
    handshake();
  endtask

  vec_t        vecs [13];
  int          lat;
  logic [21:0] r0;
  logic [511:0] snap;
  bit          bad;

  initial begin
    bus.cq_tdata  = '0;
    bus.cq_tuser  = '0;
    bus.cq_tkeep  = '0;
    bus.cq_tlast  = 1'b0;
    bus.cq_tvalid = 1'b0;
    bus.cc_tready = 1'b0;

    vecs[0]  = '{1, 64'h8,  4'hF,    32'hDEADBEEF, 11'd1, 8'h01, 3'd0, 3'd0, 3'd0,
                 1, 8'd2, 0, 3'd0, 13'd0, 7'h00, 11'd0, 32'h0, 16'h0};
    vecs[1]  = '{0, 64'h8,  4'hF,    32'h0,        11'd1, 8'h15, 3'd0, 3'd0, 3'd0,
                 0, 8'd0, 1, 3'd0, 13'd4, 7'h08, 11'd1, 32'hDEADBEEF, 16'h000F};
    vecs[2]  = '{1, 64'hC,  4'b0110, 32'h11223344, 11'd1, 8'h02, 3'd0, 3'd0, 3'd0,
                 1, 8'd3, 0, 3'd0, 13'd0, 7'h00, 11'd0, 32'h0, 16'h0};
    vecs[3]  = '{0, 64'hC,  4'b0110, 32'h0,        11'd1, 8'h21, 3'd0, 3'd0, 3'd0,
                 0, 8'd0, 1, 3'd0, 13'd2, 7'h0D, 11'd1, 32'h00223300, 16'h000F};
    vecs[4]  = '{0, 64'h8,  4'hF,    32'h0,        11'd4, 8'h33, 3'd0, 3'd0, 3'd0,
                 0, 8'd0, 1, 3'd1, 13'd4, 7'h08, 11'd0, 32'h0, 16'h0007};
    vecs[5]  = '{0, 64'h8,  4'hF,    32'h0,        11'd1, 8'h34, 3'd1, 3'd0, 3'd0,
                 0, 8'd0, 0, 3'd0, 13'd0, 7'h00, 11'd0, 32'h0, 16'h0};
    vecs[6]  = '{1, 64'h10, 4'hF,    32'h12345678, 11'd2, 8'h35, 3'd0, 3'd0, 3'd0,
                 0, 8'd0, 0, 3'd0, 13'd0, 7'h00, 11'd0, 32'h0, 16'h0};
    vecs[7]  = '{0, 64'h10, 4'hF,    32'h0,        11'd1, 8'h40, 3'd0, 3'd0, 3'd0,
                 0, 8'd0, 1, 3'd0, 13'd4, 7'h10, 11'd1, 32'h0, 16'h000F};
    vecs[8]  = '{1, 64'h44, 4'b0001, 32'hCAFEF00D, 11'd1, 8'h41, 3'd0, 3'd0, 3'd0,
                 1, 8'd1, 0, 3'd0, 13'd0, 7'h00, 11'd0, 32'h0, 16'h0};
    vecs[9]  = '{0, 64'h44, 4'b1000, 32'h0,        11'd1, 8'h7F, 3'd0, 3'd5, 3'd2,
                 0, 8'd0, 1, 3'd0, 13'd1, 7'h47, 11'd1, 32'h0000000D, 16'h000F};
    vecs[10] = '{0, 64'h4,  4'b0000, 32'h0,        11'd1, 8'h02, 3'd0, 3'd0, 3'd0,
                 0, 8'd0, 1, 3'd0, 13'd1, 7'h04, 11'd1, 32'h0000000D, 16'h000F};
    vecs[11] = '{1, 64'h8,  4'hF,    32'h0BADF00D, 11'd1, 8'h03, 3'd1, 3'd0, 3'd0,
                 0, 8'd0, 0, 3'd0, 13'd0, 7'h00, 11'd0, 32'h0, 16'h0};
    vecs[12] = '{0, 64'h8,  4'hF,    32'h0,        11'd1, 8'h04, 3'd0, 3'd0, 3'd0,
                 0, 8'd0, 1, 3'd0, 13'd4, 7'h08, 11'd1, 32'hDEADBEEF, 16'h000F};

    #1 rst_n = 1'b0;
    #19;
    chk("rst_cq_tready", 128'(bus.cq_tready), 128'h3FFFFF);
    chk("rst_cc_tvalid", 128'(bus.cc_tvalid), 128'd0);
    chk("rst_cc_tlast", 128'(bus.cc_tlast), 128'd0);
    chk("rst_cc_tdata", bus.cc_tdata[127:0], 128'd0);
    chk("rst_cc_tkeep", 128'(bus.cc_tkeep), 128'd0);
    chk("rst_cc_tuser", 128'(bus.cc_tuser), 128'd0);
    chk("rst_wr_pulse", 128'(reg_wr_pulse), 128'd0);
    chk("rst_wr_idx", 128'(reg_wr_idx), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive_beat(mk_desc(vecs[i].wr, vecs[i].addr, vecs[i].dw, vecs[i].tag, vecs[i].bar,
                         vecs[i].tc, vecs[i].attr), vecs[i].data, vecs[i].be, 1'b1);
      chk($sformatf("v%0d_pulse", i), 128'(reg_wr_pulse), 128'(vecs[i].exp_pulse));
      if (vecs[i].exp_pulse) chk($sformatf("v%0d_idx", i), 128'(reg_wr_idx), 128'(vecs[i].exp_idx));
      if (vecs[i].exp_cpl) begin
        wait_cc(lat, r0);
        chk($sformatf("v%0d_latency", i), 128'(lat), 128'd2);
        chk($sformatf("v%0d_cq_bp", i), 128'(r0), 128'd0);
        chk($sformatf("v%0d_desc", i), bus.cc_tdata[127:0], exp_desc(vecs[i]));
        chk($sformatf("v%0d_upper", i), 128'(bus.cc_tdata[511:128] != '0), 128'd0);
        chk($sformatf("v%0d_keep", i), 128'(bus.cc_tkeep), 128'(vecs[i].exp_keep));
        chk($sformatf("v%0d_tlast", i), 128'(bus.cc_tlast), 128'd1);
        handshake();
      end else begin
        no_cc($sformatf("v%0d_no_cc", i));
      end
    end

    // Backpressure: second read is presented while the first completion is stalled.
    drive_beat(mk_desc(1'b0, 64'h8, 11'd1, 8'h55, 3'd0, 3'd0, 3'd0), 32'd0, 4'hF, 1'b1);
    wait_cc(lat, r0);
    snap = bus.cc_tdata;
    bus.cq_tdata[127:0] = mk_desc(1'b0, 64'hC, 11'd1, 8'h56, 3'd0, 3'd0, 3'd0);
    bus.cq_tuser[3:0]   = 4'hF;
    bus.cq_tlast        = 1'b1;
    bus.cq_tvalid       = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.cc_tvalid || (bus.cc_tdata !== snap) || (bus.cq_tready != '0)) bad = 1'b1;
    end
    chk("bp_stable", 128'(bad), 128'd0);
    chk("bp_first_tag", 128'(bus.cc_tdata[71:64]), 128'h55);
    handshake();
    @(negedge clk);
    chk("bp_second_ready", 128'(bus.cq_tready[0]), 128'd1);
    @(posedge clk);
    #1 bus.cq_tvalid = 1'b0;
    wait_cc(lat, r0);
    chk("bp_second_latency", 128'(lat), 128'd2);
    chk("bp_second_tag", 128'(bus.cc_tdata[71:64]), 128'h56);
    chk("bp_second_payload", 128'(bus.cc_tdata[127:96]), 128'h00223300);
    handshake();

    // Two-beat UR read: completion first, then the trailing beat is drained and not decoded.
    drive_beat(mk_desc(1'b0, 64'h8, 11'd4, 8'h60, 3'd0, 3'd0, 3'd0), 32'd0, 4'hF, 1'b0);
    wait_cc(lat, r0);
    chk("ur2_status", 128'(bus.cc_tdata[45:43]), 128'd1);
    chk("ur2_keep", 128'(bus.cc_tkeep), 128'h7);
    handshake();
    drive_beat(mk_desc(1'b1, 64'h14, 11'd1, 8'h61, 3'd0, 3'd0, 3'd0), 32'h55555555, 4'hF, 1'b1);
    chk("ur2_drain_no_pulse", 128'(reg_wr_pulse), 128'd0);
    no_cc("ur2_drain_no_cc");

    // Two-beat MemWr with dw_cnt 20 is dropped.
    drive_beat(mk_desc(1'b1, 64'h8, 11'd20, 8'h62, 3'd0, 3'd0, 3'd0), 32'h99999999, 4'hF, 1'b0);
    chk("wr20_no_pulse0", 128'(reg_wr_pulse), 128'd0);
    drive_beat(mk_desc(1'b1, 64'h8, 11'd1, 8'h63, 3'd0, 3'd0, 3'd0), 32'h77777777, 4'hF, 1'b1);
    chk("wr20_no_pulse1", 128'(reg_wr_pulse), 128'd0);
    no_cc("wr20_no_cc");
    rd_check("after_drain_idx5", 64'h14, 8'h64, 32'h0);
    rd_check("after_drain_idx2", 64'h8, 8'h65, 32'hDEADBEEF);

    // Reset while a completion is pending.
    drive_beat(mk_desc(1'b0, 64'h8, 11'd1, 8'h70, 3'd0, 3'd0, 3'd0), 32'd0, 4'hF, 1'b1);
    wait_cc(lat, r0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstcpl_cc_tvalid", 128'(bus.cc_tvalid), 128'd0);
    chk("rstcpl_cq_tready", 128'(bus.cq_tready), 128'h3FFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    no_cc("rstcpl_no_cc");
    rd_check("rstcpl_reg_cleared", 64'h8, 8'h71, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_pcie_cq_cc_responder.md
Name: dma_pcie_cq_cc_responder

Overview:
- Completer-side endpoint for the PCIe CQ/CC AXI-Stream pair.
- Slave on the CQ stream: consumes host memory requests targeting one BAR. Master on the CC stream: returns completions.
- Backs a small 32-bit register file, used as the default BAR responder in the QDMA EP example design.
- Straddle disabled: at most one TLP starts per CQ beat, and the descriptor occupies the first 128 bits.

Parameters:
- DATA_WIDTH, 512, CQ/CC tdata width.
- CQ_USER_WIDTH, 183, CQ tuser width.
- CC_USER_WIDTH, 81, CC tuser width.
- NUM_REGS, 16, number of 32-bit registers, power of 2, at most 256.
- BAR_ID, 0, CQ BAR id (desc[114:112]) accepted; all other BARs are dropped.

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  async active-low reset
- cq_tdata  in  DATA_WIDTH  CQ beat data (descriptor [127:0], payload DW0 at [159:128])
- cq_tuser  in  CQ_USER_WIDTH  [3:0] first_be; other bits ignored
- cq_tlast  in  1  end of TLP
- cq_tkeep  in  DATA_WIDTH/32  DW valid
- cq_tvalid  in  1  beat valid
- cq_tready  out  22  all 22 bits driven identically
- cc_tdata  out  DATA_WIDTH  completion beat
- cc_tuser  out  CC_USER_WIDTH  driven all-zero
- cc_tlast  out  1  always 1 while cc_tvalid
- cc_tkeep  out  DATA_WIDTH/32  16'h000F for CplD, 16'h0007 for Cpl
- cc_tvalid  out  1  completion valid
- cc_tready  in  1  completion accept
- completer_id  in  16  bus/dev/func placed in CC desc[87:72]
- reg_wr_pulse  out  1  one-cycle strobe on each register write
- reg_wr_idx  out  8  index written

Behaviour:
- Clock and reset: one clock, axi_aclk; reset axi_aresetn is asynchronous, active-low.
- Reset values:
  - cq_tready = 22'h3FFFFF.
  - cc_tvalid, cc_tlast, reg_wr_pulse = 0; cc_tdata, cc_tkeep, cc_tuser, reg_wr_idx = 0.
  - All registers = 0; FSM = IDLE.
- CQ descriptor decode:
  - addr = desc[63:2]; dw_cnt = desc[74:64]; req_type = desc[78:75] (0 = MemRd, 1 = MemWr).
  - req_id = desc[95:80]; tag = desc[103:96]; bar = desc[114:112]; tc = desc[123:121]; attr = desc[126:124].
- Register index: idx = addr[log2(NUM_REGS)+1:2] taken from the byte address, i.e. DW-aligned, wrapping modulo NUM_REGS.
- FSM states:
  - IDLE: cq_tready all 1. An accepted SOP beat (cq_tvalid & cq_tready) is classified as follows.
    - MemWr, bar == BAR_ID, dw_cnt == 1: byte-enable write of payload DW0 into reg[idx] using first_be. reg_wr_pulse = 1 on the next cycle.
    - MemRd, bar == BAR_ID: latch the completion fields and go to CPL. Status is SC if dw_cnt == 1, otherwise UR (status 3'b001, no payload).
    - Anything else: dropped. No completion, including writes with dw_cnt > 1.
    - Any classification with cq_tlast = 0: go to DRAIN after the action. A read that needs a completion goes to CPL first, then DRAIN if required.
  - DRAIN: cq_tready = 1; discard beats until an accepted beat with cq_tlast = 1, then return to IDLE.
  - CPL: cq_tready = 0 and cc_tvalid = 1, with cc_tdata held stable until cc_tready. On cc_tvalid & cc_tready, go to IDLE (or DRAIN if pending), clear cc_tvalid, and reassert cq_tready the following cycle.
- CC descriptor:
  - [6:0] lower_addr = {addr[6:2], lo2}, where lo2 is the offset of the first set bit of first_be (00 if first_be = 0).
  - [28:16] byte_count = span of first_be, from first set to last set bit inclusive (0000 gives 1, 1111 gives 4, 0110 gives 2). UR byte_count = 4.
  - [42:32] dword_count = 1 for SC, 0 for UR.
  - [45:43] status; [63:48] req_id; [71:64] tag; [87:72] completer_id; [88] = 0; [91:89] tc; [94:92] attr.
  - [127:96] = reg[idx] as captured when the request was accepted. A same-index write on a later cycle does not alter it.
- Latency: CQ accept to cc_tvalid = 2 cycles (decode register, then read/format register).
- Ordering: one outstanding completion. No CQ beat is accepted while in CPL, so CQ backpressure starts at the acceptance cycle.
- Reset mid-CPL: cc_tvalid drops asynchronously and the completion is lost; the host times out.

Optional Feature:
- Macro: DMA_CQ_CC_RESP_STATS_EN.
- Defined: adds output ports stat_rd_cnt[31:0], stat_wr_cnt[31:0] and stat_ur_cnt[31:0].
  - Counts are of accepted SC reads, performed writes and UR completions respectively.
  - Counters saturate at 32'hFFFFFFFF and reset to 0.
  - stat_rd_cnt and stat_ur_cnt increment on the CC handshake.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Write then read: MemWr to addr 0x8, first_be 4'hF, data 0xDEADBEEF, dw_cnt 1 → reg_wr_pulse with reg_wr_idx 2. Then MemRd of the same address, tag 0x15 → CplD with status 0, byte_count 4, lower_addr 0x08, tag 0x15, payload 0xDEADBEEF, cc_tkeep 16'h000F.
- Partial byte enables: MemWr 0x11223344 to idx 3 with first_be 4'b0110, over prior value 0 → reg 0x00223300. MemRd with first_be 4'b0110 → byte_count 2, lower_addr[1:0] = 01.
- UR path: MemRd with dw_cnt 4 → Cpl with status 3'b001, dword_count 0, cc_tkeep 16'h0007. A 2-beat MemWr with dw_cnt 20 is drained with no register change and no completion.
- Backpressure: hold cc_tready = 0 for 10 cycles after CC asserts → cc_tdata stable and cq_tready = 0 throughout. A second MemRd is accepted only after the handshake, and its completion tag is correct.
- Wrong BAR: MemRd with bar 1 while BAR_ID = 0 → no CC beat and cq_tready stays high.
- Reset mid-CPL: assert axi_aresetn = 0 while cc_tvalid = 1 → cc_tvalid = 0 immediately and reg[*] = 0. After release, cq_tready = all-ones.
